// File: rtl/prio_mixer_ctrl.sv
// rtl/prio_mixer_ctrl.sv - layer priority mixer with an internal 256x4 priority table and a deferred loader
// Optional build macro: PRIO_LAYER_MASK_EN adds LAYER_MASK for debug layer toggling.
module prio_mixer_ctrl #(
    parameter int              PW       = 12,
    parameter logic [PW-1:0]   BACKDROP = 12'h000
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE_PIX,
    input  logic          BLANK,
    input  logic [2:0]    OBP,
    input  logic [PW-1:0] FIX_PIX,
    input  logic [PW-1:0] OBJ_PIX,
    input  logic [PW-1:0] VA_PIX,
    input  logic [PW-1:0] VB_PIX,
    output logic [PW-1:0] PIX_OUT,
    output logic          PIX_VALID,
    output logic          SHADOW,
    input  logic          DL_REQ,
    input  logic [7:0]    DL_ADDR,
    input  logic [3:0]    DL_DATA,
    output logic          DL_ACK,
    input  logic          DL_FORCE
`ifdef PRIO_LAYER_MASK_EN
    ,
    input  logic [3:0]    LAYER_MASK
`endif
);

    typedef enum logic [1:0] {L_IDLE, L_WAIT, L_WRITE, L_DONE} ld_state_t;

    ld_state_t state_q, state_d;

    // Layer order everywhere: [0]=FIX, [1]=OBJ, [2]=VA, [3]=VB, matching table codes 0..3
    logic [3:0][PW-1:0] pix0_q, pix1_q;
    logic [7:0]         addr0_q;
    logic [3:0]         mask0_q, mask1_q;
    logic               blank0_q, blank1_q;
    logic               v0_q, v1_q;
    logic [3:0]         rd_q;
    logic [3:0]         mem_q [0:255];

    logic [PW-1:0]      pix_out_q;
    logic               shadow_q, valid_q;

    logic [3:0]         mask_w;
    logic               n_fix, n_obj, n_va, n_vb;
    logic [7:0]         lookup_addr;
    logic               wr_grant, step;
    logic [PW-1:0]      sel_pix;

`ifdef PRIO_LAYER_MASK_EN
    assign mask_w = LAYER_MASK;
`else
    assign mask_w = 4'b0000;
`endif

    assign n_fix = (FIX_PIX[3:0] == 4'd0) | mask_w[0];
    assign n_obj = (OBJ_PIX[3:0] == 4'd0) | mask_w[1];
    assign n_va  = (VA_PIX[3:0]  == 4'd0) | mask_w[2];
    assign n_vb  = (VB_PIX[3:0]  == 4'd0) | mask_w[3];

    // OBP bits land reversed in A6..A4; A7 is never driven so the upper half is write-only
    assign lookup_addr = {1'b0, OBP[0], OBP[1], OBP[2], n_fix, n_obj, n_vb, n_va};

    // The loader owns the RAM port in WRITE; a forced load freezes the video path entirely
    assign wr_grant = (state_q == L_WRITE);
    assign step     = CE_PIX & ~wr_grant & ~DL_FORCE;

    assign DL_ACK    = wr_grant;
    assign PIX_OUT   = pix_out_q;
    assign SHADOW    = shadow_q;
    assign PIX_VALID = valid_q;

    // Loader state register; reset abandons any pending write without acknowledging it
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= L_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Loader next state: writes wait for blanking unless forced, and a held request writes once
    always_comb begin
        state_d = state_q;
        case (state_q)
            L_IDLE:  if (DL_REQ) state_d = (BLANK | DL_FORCE) ? L_WRITE : L_WAIT;
            L_WAIT:  if (BLANK | DL_FORCE) state_d = L_WRITE;
            L_WRITE: state_d = L_DONE;
            L_DONE:  if (!DL_REQ) state_d = L_IDLE;
            default: state_d = L_IDLE;
        endcase
    end

    // Single-port table: loader write or one video read per step, never both
    always_ff @(posedge CLK) begin
        if (wr_grant) begin
            mem_q[DL_ADDR] <= DL_DATA;
        end else if (step) begin
            rd_q <= mem_q[addr0_q];
        end
    end

    // Capture and read-stage registers; blank and mask travel with their pixel
    always_ff @(posedge CLK) begin
        if (RST) begin
            pix0_q   <= '0;
            pix1_q   <= '0;
            addr0_q  <= '0;
            mask0_q  <= '0;
            mask1_q  <= '0;
            blank0_q <= 1'b0;
            blank1_q <= 1'b0;
            v0_q     <= 1'b0;
            v1_q     <= 1'b0;
        end else if (step) begin
            pix0_q   <= {VB_PIX, VA_PIX, OBJ_PIX, FIX_PIX};
            addr0_q  <= lookup_addr;
            mask0_q  <= mask_w;
            blank0_q <= BLANK;
            v0_q     <= 1'b1;
            pix1_q   <= pix0_q;
            mask1_q  <= mask0_q;
            blank1_q <= blank0_q;
            v1_q     <= v0_q;
        end
    end

    // Decode the table entry into the winning layer; codes 4..7 and masked winners give backdrop
    always_comb begin
        sel_pix = BACKDROP;
        if (!blank1_q && !rd_q[2] && !mask1_q[rd_q[1:0]]) begin
            sel_pix = pix1_q[rd_q[1:0]];
        end
    end

    // Output stage: PIX_OUT holds between pixels, PIX_VALID pulses only on a completed lookup
    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_out_q <= BACKDROP;
            shadow_q  <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            valid_q <= step & v1_q;
            if (step && v1_q) begin
                pix_out_q <= sel_pix;
                shadow_q  <= rd_q[3];
            end
        end
    end

endmodule

// File: tb/tb_prio_mixer_ctrl.sv
// tb/tb_prio_mixer_ctrl.sv - randomized self-checking bench for prio_mixer_ctrl
module tb_prio_mixer_ctrl;

    localparam logic [11:0] TB_BACKDROP = 12'hB00;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        CE_PIX = 1'b0;
    logic        BLANK = 1'b0;
    logic [2:0]  OBP = 3'd0;
    logic [11:0] FIX_PIX = 12'd0, OBJ_PIX = 12'd0, VA_PIX = 12'd0, VB_PIX = 12'd0;
    logic [11:0] PIX_OUT;
    logic        PIX_VALID, SHADOW;
    logic        DL_REQ = 1'b0;
    logic [7:0]  DL_ADDR = 8'd0;
    logic [3:0]  DL_DATA = 4'd0;
    logic        DL_ACK;
    logic        DL_FORCE = 1'b0;

    int checks = 0;
    int errors = 0;

    prio_mixer_ctrl #(.PW(12), .BACKDROP(TB_BACKDROP)) dut (
        .CLK(CLK), .RST(RST), .CE_PIX(CE_PIX), .BLANK(BLANK), .OBP(OBP),
        .FIX_PIX(FIX_PIX), .OBJ_PIX(OBJ_PIX), .VA_PIX(VA_PIX), .VB_PIX(VB_PIX),
        .PIX_OUT(PIX_OUT), .PIX_VALID(PIX_VALID), .SHADOW(SHADOW),
        .DL_REQ(DL_REQ), .DL_ADDR(DL_ADDR), .DL_DATA(DL_DATA), .DL_ACK(DL_ACK),
        .DL_FORCE(DL_FORCE)
    );

    always #5 CLK = ~CLK;

    // Reference model: the table contents plus the pixels still in flight, oldest first
    typedef struct {
        logic [3:0][11:0] pix;
        logic [7:0]       addr;
        bit               blank;
        logic [11:0]      out;
        bit               sh;
    } item_t;

    logic [3:0] tbl [256];
    item_t      q [$];

    // One accepted pixel: the previous pixel reads the table now, the one before that is output
    task automatic model_push(input logic [11:0] f, o, a, b, input logic [2:0] obp, input bit blank,
                              output bit ev, output logic [11:0] eo, output bit es);
        item_t it, r;
        logic [3:0] e;
        int n;
        it.pix   = {b, a, o, f};
        it.addr  = {1'b0, obp[0], obp[1], obp[2], (f[3:0] == 4'd0), (o[3:0] == 4'd0),
                    (b[3:0] == 4'd0), (a[3:0] == 4'd0)};
        it.blank = blank;
        it.out   = 12'd0;
        it.sh    = 1'b0;
        q.push_back(it);
        n = q.size();
        if (n >= 2) begin
            r = q[n-2];
            e = tbl[r.addr];
            r.sh = e[3];
            if (r.blank || e[2:0] > 3'd3) r.out = TB_BACKDROP;
            else r.out = r.pix[e[1:0]];
            q[n-2] = r;
        end
        ev = (n >= 3);
        eo = 12'd0;
        es = 1'b0;
        if (ev) begin
            r  = q.pop_front();
            eo = r.out;
            es = r.sh;
        end
    endtask

    // Drive one pixel with CE_PIX for one clock, then sample outputs mid-cycle
    task automatic ce_step(input logic [11:0] f, o, a, b, input logic [2:0] obp, input bit blank,
                           output bit gv, output logic [11:0] go, output bit gs);
        @(negedge CLK);
        FIX_PIX = f; OBJ_PIX = o; VA_PIX = a; VB_PIX = b; OBP = obp; BLANK = blank;
        CE_PIX = 1'b1;
        @(negedge CLK);
        CE_PIX = 1'b0;
        gv = PIX_VALID; go = PIX_OUT; gs = SHADOW;
    endtask

    // Full four-phase loader handshake with a cycle budget; CE_PIX keeps toggling throughout
    task automatic dl_write(input logic [7:0] a, input logic [3:0] d,
                            output int acks, output bit saw_valid, output bit timeout);
        acks = 0; saw_valid = 1'b0; timeout = 1'b1;
        @(negedge CLK);
        DL_ADDR = a; DL_DATA = d; DL_REQ = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge CLK);
            CE_PIX = ~CE_PIX;
            if (PIX_VALID) saw_valid = 1'b1;
            if (DL_ACK) begin acks++; timeout = 1'b0; break; end
        end
        DL_REQ = 1'b0;
        @(negedge CLK);
        CE_PIX = ~CE_PIX;
        if (PIX_VALID) saw_valid = 1'b1;
        if (DL_ACK) acks++;
    endtask

    function automatic logic [11:0] rand_pix();
        logic [11:0] p;
        p = 12'($urandom_range(0, 4095));
        if ($urandom_range(0, 2) == 0) p[3:0] = 4'd0;
        return p;
    endfunction

    task automatic test_reset();
        @(negedge CLK);
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        checks++;
        if (PIX_OUT !== TB_BACKDROP) begin errors++; $display("FAIL reset_pix_out got %h exp %h", PIX_OUT, TB_BACKDROP); end
        checks++;
        if (PIX_VALID !== 1'b0 || SHADOW !== 1'b0 || DL_ACK !== 1'b0) begin
            errors++; $display("FAIL reset_flags got valid=%b shadow=%b ack=%b exp 0 0 0", PIX_VALID, SHADOW, DL_ACK);
        end
        q.delete();
    endtask

    task automatic test_force_load();
        int acks, total, tmo;
        bit sv, to, any_valid;
        total = 0; tmo = 0; any_valid = 1'b0;
        DL_FORCE = 1'b1;
        for (int a = 0; a < 256; a++) begin
            logic [3:0] d;
            d = 4'($urandom_range(0, 15));
            if (a == 8'h00) d = 4'h0;
            if (a == 8'h0E) d = 4'hA;
            if (a == 8'h0F) d = 4'h4;
            tbl[a] = d;
            dl_write(8'(a), d, acks, sv, to);
            total += acks;
            if (to) tmo++;
            if (sv) any_valid = 1'b1;
        end
        DL_FORCE = 1'b0;
        CE_PIX = 1'b0;
        checks++;
        if (total != 256) begin errors++; $display("FAIL force_ack_count got %0d exp 256", total); end
        checks++;
        if (tmo != 0) begin errors++; $display("FAIL force_ack_timeout got %0d exp 0", tmo); end
        checks++;
        if (any_valid !== 1'b0) begin errors++; $display("FAIL force_no_valid got %b exp 0", any_valid); end
    endtask

    task automatic test_plan_vectors();
        logic [11:0] vf [6], vo [6], va [6], vb [6];
        bit vbl [6];
        bit gv, gs, ev, es;
        logic [11:0] go, eo;
        vf[0] = 12'h005; vo[0] = 12'h013; va[0] = 12'h021; vb[0] = 12'h031; vbl[0] = 1'b0;
        vf[1] = 12'h000; vo[1] = 12'h000; va[1] = 12'h042; vb[1] = 12'h000; vbl[1] = 1'b0;
        vf[2] = 12'h070; vo[2] = 12'h080; va[2] = 12'h090; vb[2] = 12'h0A0; vbl[2] = 1'b0;
        vf[3] = 12'h070; vo[3] = 12'h080; va[3] = 12'h090; vb[3] = 12'h0A0; vbl[3] = 1'b1;
        vf[4] = 12'h005; vo[4] = 12'h013; va[4] = 12'h021; vb[4] = 12'h031; vbl[4] = 1'b1;
        vf[5] = 12'h005; vo[5] = 12'h013; va[5] = 12'h021; vb[5] = 12'h031; vbl[5] = 1'b0;
        for (int i = 0; i < 6; i++) begin
            ce_step(vf[i], vo[i], va[i], vb[i], 3'd0, vbl[i], gv, go, gs);
            model_push(vf[i], vo[i], va[i], vb[i], 3'd0, vbl[i], ev, eo, es);
            checks++;
            if (gv !== ev) begin errors++; $display("FAIL plan_valid[%0d] got %b exp %b", i, gv, ev); end
            if (ev) begin
                checks++;
                if (go !== eo || gs !== es) begin
                    errors++; $display("FAIL plan_pixel[%0d] got %h/%b exp %h/%b", i, go, gs, eo, es);
                end
            end
            if (i == 2) begin
                checks++;
                if (go !== 12'h005) begin errors++; $display("FAIL plan_first_result got %h exp 005", go); end
            end
        end
    endtask

    task automatic test_random_lookup();
        bit gv, gs, ev, es, bl;
        logic [11:0] go, eo, f, o, a, b;
        logic [2:0] obp;
        int bad;
        bad = 0;
        for (int i = 0; i < 200; i++) begin
            f = rand_pix(); o = rand_pix(); a = rand_pix(); b = rand_pix();
            obp = 3'($urandom_range(0, 7));
            bl = ($urandom_range(0, 3) == 0);
            ce_step(f, o, a, b, obp, bl, gv, go, gs);
            model_push(f, o, a, b, obp, bl, ev, eo, es);
            checks++;
            if (gv !== ev || (ev && (go !== eo || gs !== es))) begin
                errors++; bad++;
                if (bad < 10) $display("FAIL random[%0d] got v=%b %h/%b exp v=%b %h/%b", i, gv, go, gs, ev, eo, es);
            end
        end
    endtask

    task automatic test_loader_deferred();
        int acks;
        bit gv, gs, ev, es;
        logic [11:0] go, eo, f, o, a, b;
        @(negedge CLK);
        BLANK = 1'b0; DL_ADDR = 8'h55; DL_DATA = 4'hA; DL_REQ = 1'b1;
        acks = 0;
        repeat (6) begin @(negedge CLK); if (DL_ACK) acks++; end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL ack_before_blank got %0d exp 0", acks); end
        BLANK = 1'b1;
        @(negedge CLK);
        checks++;
        if (DL_ACK !== 1'b1) begin errors++; $display("FAIL ack_after_blank got %b exp 1", DL_ACK); end
        CE_PIX = 1'b1;
        @(negedge CLK);
        CE_PIX = 1'b0;
        checks++;
        if (DL_ACK !== 1'b0) begin errors++; $display("FAIL ack_width got %b exp 0", DL_ACK); end
        checks++;
        if (PIX_VALID !== 1'b0) begin errors++; $display("FAIL skip_on_write got %b exp 0", PIX_VALID); end
        acks = 0;
        repeat (5) begin @(negedge CLK); if (DL_ACK) acks++; end
        checks++;
        if (acks != 0) begin errors++; $display("FAIL no_rewrite_held_req got %0d exp 0", acks); end
        DL_REQ = 1'b0;
        BLANK = 1'b0;
        tbl[8'h55] = 4'hA;
        for (int i = 0; i < 3; i++) begin
            if (i == 0) begin f = 12'h015; o = 12'h020; a = 12'h0F0; b = 12'h03C; end
            else begin f = rand_pix(); o = rand_pix(); a = rand_pix(); b = rand_pix(); end
            ce_step(f, o, a, b, 3'b101, 1'b0, gv, go, gs);
            model_push(f, o, a, b, 3'b101, 1'b0, ev, eo, es);
            checks++;
            if (gv !== ev || (ev && (go !== eo || gs !== es))) begin
                errors++; $display("FAIL readback_55[%0d] got v=%b %h/%b exp v=%b %h/%b", i, gv, go, gs, ev, eo, es);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int acks;
        bit gv, gs, ev, es;
        logic [11:0] go, eo;
        @(negedge CLK);
        BLANK = 1'b0; DL_ADDR = 8'h0F; DL_DATA = 4'h3; DL_REQ = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        DL_REQ = 1'b0;
        q.delete();
        checks++;
        if (PIX_OUT !== TB_BACKDROP || PIX_VALID !== 1'b0 || SHADOW !== 1'b0 || DL_ACK !== 1'b0) begin
            errors++; $display("FAIL wait_reset_outputs got %h %b %b %b exp %h 0 0 0", PIX_OUT, PIX_VALID, SHADOW, DL_ACK, TB_BACKDROP);
        end
        BLANK = 1'b1;
        acks = 0;
        repeat (4) begin @(negedge CLK); if (DL_ACK) acks++; end
        BLANK = 1'b0;
        checks++;
        if (acks != 0) begin errors++; $display("FAIL wait_reset_no_ack got %0d exp 0", acks); end
        for (int i = 0; i < 3; i++) begin
            ce_step(12'h070, 12'h080, 12'h090, 12'h0C0, 3'd0, 1'b0, gv, go, gs);
            model_push(12'h070, 12'h080, 12'h090, 12'h0C0, 3'd0, 1'b0, ev, eo, es);
            checks++;
            if (gv !== ev || (ev && (go !== eo || gs !== es))) begin
                errors++; $display("FAIL wait_reset_table[%0d] got v=%b %h/%b exp v=%b %h/%b", i, gv, go, gs, ev, eo, es);
            end
        end
    endtask

    initial begin
        test_reset();
        test_force_load();
        test_plan_vectors();
        test_random_lookup();
        test_loader_deferred();
        test_reset_in_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
